// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_arbiter_if: request, response and ALU-side signals of alu_arbiter
// Rev 1.0
// ------------------------------------------------------------------
interface alu_arbiter_if #(
   parameter int N = 8
);
   logic          req0_valid;
   logic          req0_ready;
   logic [N-1:0]  req0_a;
   logic [N-1:0]  req0_b;
   logic [2:0]    req0_op;
   logic          req1_valid;
   logic          req1_ready;
   logic [N-1:0]  req1_a;
   logic [N-1:0]  req1_b;
   logic [2:0]    req1_op;
   logic          resp_valid;
   logic          resp_ready;
   logic          resp_id;
   logic [N-1:0]  resp_result;
   logic          resp_carry;
   logic          resp_zero;
   logic [N-1:0]  alu_a;
   logic [N-1:0]  alu_b;
   logic [2:0]    alu_op;
   logic          alu_en;
   logic [N-1:0]  alu_result;
   logic          alu_carry;
   logic          alu_zero;

   // Arbiter side
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  resp_ready, alu_result, alu_carry, alu_zero,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_result, resp_carry, resp_zero,
      output alu_a, alu_b, alu_op, alu_en
   );

   // Requester / response consumer / ALU side
   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output resp_ready, alu_result, alu_carry, alu_zero,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_result, resp_carry, resp_zero,
      input  alu_a, alu_b, alu_op, alu_en
   );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_arbiter: round-robin sharing of one registered ALU by two ports
// with a private carry context per port. Rev 1.0
// ------------------------------------------------------------------
module alu_arbiter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);
   localparam logic [2:0] S_INIT    = 3'd0;
   localparam logic [2:0] S_IDLE    = 3'd1;
   localparam logic [2:0] S_RESTORE = 3'd2;
   localparam logic [2:0] S_ISSUE   = 3'd3;
   localparam logic [2:0] S_CAPT    = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;

   localparam logic [2:0] OP_ADD    = 3'd0;
   localparam logic [2:0] OP_ADC    = 3'd1;
   localparam logic [2:0] OP_LASTC  = 3'd4;

   logic [2:0]   state_q, state_d;
   logic [N-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]   op_q, op_d;
   logic         grant_q, grant_d;
   logic         last_grant_q, last_grant_d;
   logic [1:0]   saved_carry_q, saved_carry_d;
   logic         cur_carry_q, cur_carry_d;
   logic         resp_valid_q, resp_valid_d;
   logic         resp_id_q, resp_id_d;
   logic [N-1:0] resp_result_q, resp_result_d;
   logic         resp_carry_q, resp_carry_d;
   logic         resp_zero_q, resp_zero_d;

   logic         sel;
   logic         any_valid;
   logic [2:0]   sel_op;
   logic         ready0, ready1;
   logic         alu_en;
   logic [N-1:0] alu_a, alu_b;
   logic [2:0]   alu_op;

   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      op_d          = op_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      saved_carry_d = saved_carry_q;
      cur_carry_d   = cur_carry_q;
      resp_valid_d  = resp_valid_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      resp_carry_d  = resp_carry_q;
      resp_zero_d   = resp_zero_q;
      alu_en        = 1'b0;
      alu_a         = '0;
      alu_b         = '0;
      alu_op        = OP_ADD;

      // Contention goes to the port that did not win last time
      any_valid = bus.req0_valid | bus.req1_valid;
      sel       = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
      sel_op    = sel ? bus.req1_op : bus.req0_op;
      ready0    = (state_q == S_IDLE) && any_valid && !sel;
      ready1    = (state_q == S_IDLE) && any_valid && sel;

      case (state_q)
         S_INIT: begin
            alu_en  = 1'b1;
            state_d = S_IDLE;
         end
         S_IDLE: begin
            if (any_valid) begin
               grant_d      = sel;
               last_grant_d = sel;
               a_d          = sel ? bus.req1_a : bus.req0_a;
               b_d          = sel ? bus.req1_b : bus.req0_b;
               op_d         = sel_op;
               if (sel_op == OP_ADC && cur_carry_q != saved_carry_q[sel])
                  state_d = S_RESTORE;
               else
                  state_d = S_ISSUE;
            end
         end
         S_RESTORE: begin
            // 0xFF+0x01 forces carry=1, 0x00+0x00 forces carry=0
            alu_en      = 1'b1;
            alu_a       = {N{saved_carry_q[grant_q]}};
            alu_b       = {{(N-1){1'b0}}, saved_carry_q[grant_q]};
            cur_carry_d = saved_carry_q[grant_q];
            state_d     = S_ISSUE;
         end
         S_ISSUE: begin
            alu_en  = 1'b1;
            alu_a   = a_q;
            alu_b   = b_q;
            alu_op  = op_q;
            state_d = S_CAPT;
         end
         S_CAPT: begin
            resp_valid_d  = 1'b1;
            resp_id_d     = grant_q;
            resp_result_d = bus.alu_result;
            resp_carry_d  = bus.alu_carry;
            resp_zero_d   = bus.alu_zero;
            if (op_q <= OP_LASTC) begin
               cur_carry_d            = bus.alu_carry;
               saved_carry_d[grant_q] = bus.alu_carry;
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_INIT;
         a_q           <= '0;
         b_q           <= '0;
         op_q          <= 3'd0;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         saved_carry_q <= 2'b00;
         cur_carry_q   <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= 1'b0;
         resp_result_q <= '0;
         resp_carry_q  <= 1'b0;
         resp_zero_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         op_q          <= op_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         saved_carry_q <= saved_carry_d;
         cur_carry_q   <= cur_carry_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
         resp_carry_q  <= resp_carry_d;
         resp_zero_q   <= resp_zero_d;
      end
   end

   assign bus.req0_ready  = ready0;
   assign bus.req1_ready  = ready1;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_id     = resp_id_q;
   assign bus.resp_result = resp_result_q;
   assign bus.resp_carry  = resp_carry_q;
   assign bus.resp_zero   = resp_zero_q;
   assign bus.alu_en      = alu_en;
   assign bus.alu_a       = alu_a;
   assign bus.alu_b       = alu_b;
   assign bus.alu_op      = alu_op;
endmodule
`default_nettype wire
